deparser_head_merge: RTL and testbench
======================================

Name: deparser_head_merge

Overview:
- Sits directly downstream of the last deparser layer stage.
- Captures the rebuilt header (head + tag) and its byte length from the fixed-latency deparser pipeline into a small FIFO.
- Pairs each header, in order, with the payload stream of the same packet and emits one byte-contiguous output packet stream: header bytes first, then the payload realigned behind them.
- Also handles drop-tagged packets and output backpressure.

Parameters:
- DATA_WIDTH, 512: stream beat width in bits; DATA_BYTES = DATA_WIDTH/8.
- HEAD_WIDTH, 1024: header width in bits; HEAD_BYTES = HEAD_WIDTH/8. Must be a multiple of DATA_WIDTH.
- TAG_WIDTH, 8: tag width. Bit TAG_WIDTH-1 = valid, bit TAG_WIDTH-2 = drop, remaining bits = packet id (ignored here).
- HFIFO_DEPTH, 8: header FIFO entries, power of 2.
- AFULL_LEVEL, 6: occupancy at or above which o_head_afull asserts.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_head  in  HEAD_WIDTH+TAG_WIDTH  header from last deparser layer; byte 0 = MSB; tag in the top TAG_WIDTH bits
- i_head_len  in  8  valid header bytes, 0..HEAD_BYTES; sampled with i_head
- o_head_afull  out  1  header FIFO almost full; upstream stops admitting packets
- i_pay_valid  in  1  payload beat valid
- i_pay_data  in  DATA_WIDTH  payload beat; byte 0 = MSB
- i_pay_last  in  1  last payload beat of the packet
- i_pay_bytes  in  7  valid bytes on the last beat, 1..DATA_BYTES; all other beats are full
- o_pay_ready  out  1  payload accept
- o_pkt_valid  out  1  output beat valid
- o_pkt_data  out  DATA_WIDTH  output beat; byte 0 = MSB
- o_pkt_last  out  1  last output beat
- o_pkt_bytes  out  7  valid bytes on the last beat; DATA_BYTES on other beats
- i_pkt_ready  in  1  downstream accept
- o_overflow  out  1  sticky: a header arrived while the FIFO was full

Behaviour:
- Reset (asynchronous): all outputs 0, FIFO empty, state IDLE, o_overflow cleared.
- Header capture
  - Push when i_head tag valid = 1. The input has no backpressure.
  - Pushing into a full FIFO discards the header and sets o_overflow.
  - o_head_afull is registered, asserted when occupancy >= AFULL_LEVEL.
  - A simultaneous push and pop keeps occupancy unchanged.
- Handshakes: a beat transfers on valid & ready. o_pkt_valid and its data hold until accepted. o_pkt_* are driven from registers.
- State IDLE
  - When the FIFO is non-empty: pop the head, latch hlen = i_head_len.
  - Go to DROP if the drop bit is set; otherwise go to HEAD if hlen >= DATA_BYTES, else PAY.
- State HEAD
  - Emit header beat k (bytes k*DATA_BYTES ..) while remaining header bytes >= DATA_BYTES.
  - The leftover r = remaining header bytes (0..DATA_BYTES-1) stays in the residue register, MSB-aligned; then go to PAY.
- State PAY (o_pay_ready = output register free or being accepted)
  - Output beat = residue(r bytes) concatenated with the first DATA_BYTES-r bytes of the payload beat.
  - The remaining r payload bytes become the new residue.
  - On the last payload beat, compute the total tail t = r + i_pay_bytes.
    - t <= DATA_BYTES: emit it as the last beat (o_pkt_bytes = t), go to IDLE.
    - Otherwise: emit a full beat and go to FLUSH.
- State FLUSH: emit the residue, t-DATA_BYTES bytes, with o_pkt_last = 1, then go to IDLE.
- State DROP: o_pay_ready = 1 and no output; consume payload through i_pay_last, then go to IDLE.
- Header length 0: output equals the payload unchanged, 1 beat in and 1 beat out.
- Header length equal to HEAD_BYTES: exactly HEAD_BYTES/DATA_BYTES header beats with r = 0.
- Latency
  - The first output beat is valid 2 cycles after the header is pushed into an empty FIFO (pop + register).
  - No bubbles between beats of one packet when input and output are unstalled.
  - IDLE costs 1 cycle between packets.
- Unused bytes beyond o_pkt_bytes on the last beat are driven 0.
- Reset mid-packet: state, residue and FIFO are cleared. Payload beats of the aborted packet are not tracked; upstream resets together.

Test Plan:
- Header len 128, 3-beat payload (64,64,10 bytes), no stall -> 5 output beats; beats 0-1 = header bytes; last beat o_pkt_bytes = 10; first valid 2 cycles after the header push.
- Header len 42, payload 64+30 bytes -> beat0 = 42 header bytes + payload bytes 0..21; beat1 = payload bytes 22..85; beat2 last, o_pkt_bytes = 8 (FLUSH path).
- Header len 20, single payload beat of 40 bytes -> one beat with o_pkt_last = 1, o_pkt_bytes = 60.
- Drop-tagged header followed by normal header len 14: payload of pkt A fully consumed with no output; pkt B output intact. Header len 0 case: output identical to the payload.
- Random i_pkt_ready with 25% stall, 200 packets of random lengths -> byte-exact match against the reference model, and o_pkt_data stable while stalled.
- Push 9 headers with payload held off -> o_head_afull asserts after the 6th push; the 9th header is discarded and o_overflow = 1. Asserting i_rst_n = 0 mid-packet -> all outputs 0 immediately.

Source files
------------

// File: rtl/deparser_head_merge.sv
// Header/payload merge behind the last deparser layer: queues rebuilt headers and
// emits each one byte-contiguously ahead of its realigned payload stream.
module deparser_head_merge #(
    parameter int DATA_WIDTH  = 512,
    parameter int HEAD_WIDTH  = 1024,
    parameter int TAG_WIDTH   = 8,
    parameter int HFIFO_DEPTH = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
    input  logic [7:0]                      i_head_len,
    output logic                            o_head_afull,
    input  logic                            i_pay_valid,
    input  logic [DATA_WIDTH-1:0]           i_pay_data,
    input  logic                            i_pay_last,
    input  logic [6:0]                      i_pay_bytes,
    output logic                            o_pay_ready,
    output logic                            o_pkt_valid,
    output logic [DATA_WIDTH-1:0]           o_pkt_data,
    output logic                            o_pkt_last,
    output logic [6:0]                      o_pkt_bytes,
    input  logic                            i_pkt_ready,
    output logic                            o_overflow
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int PTR_W      = $clog2(HFIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_PAY   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DROP  = 3'd4
    } state_t;

    // Keep the n most significant bytes of a beat, zero the rest.
    function automatic logic [DATA_WIDTH-1:0] keep_bytes(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [7:0] n);
        logic [DATA_WIDTH-1:0] m;
        m = ~({DATA_WIDTH{1'b1}} >> {n, 3'b000});
        return d & m;
    endfunction

    // Header FIFO storage and bookkeeping
    logic [HEAD_WIDTH-1:0] fifo_head_r [HFIFO_DEPTH];
    logic [7:0]            fifo_len_r  [HFIFO_DEPTH];
    logic                  fifo_drop_r [HFIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]      count_r, count_nx_s;
    logic                  afull_r, overflow_r;
    logic                  fifo_full_s, fifo_empty_s, push_req_s, push_s, pop_s;
    logic                  unused_tag_s;

    // Datapath and output registers
    state_t                state_r, state_nx_s;
    logic [HEAD_WIDTH-1:0] hdr_r, hdr_nx_s, hdr_shift_s;
    logic [7:0]            rem_r, rem_nx_s, rem_dec_s;
    logic [DATA_WIDTH-1:0] res_r, res_nx_s;
    logic [7:0]            rcnt_r, rcnt_nx_s, tail_s;
    logic [DATA_WIDTH-1:0] pay_mask_s, pay_cat_s, pay_res_s;
    logic [10:0]           res_shl_s;
    logic                  out_valid_r, out_last_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [6:0]            out_bytes_r;
    logic                  out_free_s, load_s, ld_last_s, pay_ready_s;
    logic [DATA_WIDTH-1:0] ld_data_s;
    logic [6:0]            ld_bytes_s;

    assign unused_tag_s = ^i_head[HEAD_WIDTH+TAG_WIDTH-3:HEAD_WIDTH];
    assign push_req_s   = i_head[HEAD_WIDTH+TAG_WIDTH-1];
    assign fifo_full_s  = (count_r == CNT_W'(HFIFO_DEPTH));
    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign pop_s        = (state_r == ST_IDLE) && !fifo_empty_s;
    assign push_s       = push_req_s && !fifo_full_s;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_nx_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CNT_W'(1);
            2'b01:   count_nx_s = count_r - CNT_W'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // FIFO payload storage; validity is tracked by the pointers alone
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            fifo_head_r[wr_ptr_r] <= i_head[HEAD_WIDTH-1:0];
            fifo_len_r[wr_ptr_r]  <= i_head_len;
            fifo_drop_r[wr_ptr_r] <= i_head[HEAD_WIDTH+TAG_WIDTH-2];
        end
    end

    // FIFO pointers, occupancy and status flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            afull_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r    <= count_nx_s;
            afull_r    <= (count_nx_s >= CNT_W'(AFULL_LEVEL));
            overflow_r <= overflow_r | (push_req_s & fifo_full_s);
        end
    end

    assign out_free_s  = !out_valid_r || i_pkt_ready;
    assign hdr_shift_s = hdr_r << DATA_WIDTH;
    assign rem_dec_s   = rem_r - 8'(DATA_BYTES);
    assign tail_s      = rcnt_r + {1'b0, i_pay_bytes};
    assign res_shl_s   = 11'(DATA_WIDTH) - {rcnt_r, 3'b000};

    // Payload realignment: residue bytes first, payload shifted in behind them
    always_comb begin
        pay_mask_s = i_pay_data;
        if (i_pay_last) begin
            pay_mask_s = keep_bytes(i_pay_data, {1'b0, i_pay_bytes});
        end else begin
            pay_mask_s = i_pay_data;
        end
        pay_cat_s = res_r | (pay_mask_s >> {rcnt_r, 3'b000});
        pay_res_s = pay_mask_s << res_shl_s;
    end

    // Next-state, datapath updates and output-register load
    always_comb begin
        state_nx_s  = state_r;
        hdr_nx_s    = hdr_r;
        rem_nx_s    = rem_r;
        res_nx_s    = res_r;
        rcnt_nx_s   = rcnt_r;
        load_s      = 1'b0;
        ld_data_s   = {DATA_WIDTH{1'b0}};
        ld_last_s   = 1'b0;
        ld_bytes_s  = 7'(DATA_BYTES);
        pay_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    hdr_nx_s  = fifo_head_r[rd_ptr_r];
                    rem_nx_s  = fifo_len_r[rd_ptr_r];
                    res_nx_s  = keep_bytes(fifo_head_r[rd_ptr_r][HEAD_WIDTH-1 -: DATA_WIDTH],
                                           fifo_len_r[rd_ptr_r]);
                    rcnt_nx_s = fifo_len_r[rd_ptr_r];
                    if (fifo_drop_r[rd_ptr_r]) begin
                        state_nx_s = ST_DROP;
                    end else if (fifo_len_r[rd_ptr_r] >= 8'(DATA_BYTES)) begin
                        state_nx_s = ST_HEAD;
                    end else begin
                        state_nx_s = ST_PAY;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HEAD: begin
                if (out_free_s) begin
                    load_s    = 1'b1;
                    ld_data_s = hdr_r[HEAD_WIDTH-1 -: DATA_WIDTH];
                    hdr_nx_s  = hdr_shift_s;
                    rem_nx_s  = rem_dec_s;
                    if (rem_dec_s < 8'(DATA_BYTES)) begin
                        state_nx_s = ST_PAY;
                        res_nx_s   = keep_bytes(hdr_shift_s[HEAD_WIDTH-1 -: DATA_WIDTH], rem_dec_s);
                        rcnt_nx_s  = rem_dec_s;
                    end else begin
                        state_nx_s = ST_HEAD;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_PAY: begin
                pay_ready_s = out_free_s;
                if (i_pay_valid && out_free_s) begin
                    load_s    = 1'b1;
                    ld_data_s = pay_cat_s;
                    if (i_pay_last && (tail_s <= 8'(DATA_BYTES))) begin
                        ld_last_s  = 1'b1;
                        ld_bytes_s = tail_s[6:0];
                        res_nx_s   = {DATA_WIDTH{1'b0}};
                        rcnt_nx_s  = 8'd0;
                        state_nx_s = ST_IDLE;
                    end else if (i_pay_last) begin
                        res_nx_s   = pay_res_s;
                        rcnt_nx_s  = tail_s - 8'(DATA_BYTES);
                        state_nx_s = ST_FLUSH;
                    end else begin
                        res_nx_s = pay_res_s;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (out_free_s) begin
                    load_s     = 1'b1;
                    ld_data_s  = res_r;
                    ld_last_s  = 1'b1;
                    ld_bytes_s = rcnt_r[6:0];
                    res_nx_s   = {DATA_WIDTH{1'b0}};
                    rcnt_nx_s  = 8'd0;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_FLUSH;
                end
            end
            ST_DROP: begin
                pay_ready_s = 1'b1;
                if (i_pay_valid && i_pay_last) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DROP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and header/residue datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            hdr_r   <= {HEAD_WIDTH{1'b0}};
            rem_r   <= 8'd0;
            res_r   <= {DATA_WIDTH{1'b0}};
            rcnt_r  <= 8'd0;
        end else begin
            state_r <= state_nx_s;
            hdr_r   <= hdr_nx_s;
            rem_r   <= rem_nx_s;
            res_r   <= res_nx_s;
            rcnt_r  <= rcnt_nx_s;
        end
    end

    // Output beat register: holds until accepted downstream
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            out_bytes_r <= 7'd0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= ld_data_s;
            out_last_r  <= ld_last_s;
            out_bytes_r <= ld_bytes_s;
        end else if (i_pkt_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign o_pay_ready  = pay_ready_s;
    assign o_pkt_valid  = out_valid_r;
    assign o_pkt_data   = out_data_r;
    assign o_pkt_last   = out_last_r;
    assign o_pkt_bytes  = out_bytes_r;
    assign o_head_afull = afull_r;
    assign o_overflow   = overflow_r;

endmodule

// File: tb/tb_deparser_head_merge.sv
// Directed + random bench for deparser_head_merge with a byte-level scoreboard.
module tb_deparser_head_merge;

    localparam int DW = 512;
    localparam int HW = 1024;
    localparam int TW = 8;
    localparam int DB = 64;
    localparam int HB = 128;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic [HW+TW-1:0] i_head;
    logic [7:0]     i_head_len;
    logic           o_head_afull;
    logic           i_pay_valid;
    logic [DW-1:0]  i_pay_data;
    logic           i_pay_last;
    logic [6:0]     i_pay_bytes;
    logic           o_pay_ready;
    logic           o_pkt_valid;
    logic [DW-1:0]  o_pkt_data;
    logic           o_pkt_last;
    logic [6:0]     o_pkt_bytes;
    logic           i_pkt_ready;
    logic           o_overflow;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic [6:0]    bytes;
    } beat_t;

    beat_t      sb[$];
    logic [7:0] pay_q[$];
    int         checks = 0;
    int         errors = 0;
    int         ready_mode = 0;
    bit         mon_en = 1'b1;
    int         pkt_id = 0;

    deparser_head_merge dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_head(i_head), .i_head_len(i_head_len),
        .o_head_afull(o_head_afull), .i_pay_valid(i_pay_valid), .i_pay_data(i_pay_data),
        .i_pay_last(i_pay_last), .i_pay_bytes(i_pay_bytes), .o_pay_ready(o_pay_ready),
        .o_pkt_valid(o_pkt_valid), .o_pkt_data(o_pkt_data), .o_pkt_last(o_pkt_last),
        .o_pkt_bytes(o_pkt_bytes), .i_pkt_ready(i_pkt_ready), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Header push; the model expectation is queued before the header enters the DUT
    task automatic start_pkt(input int hlen, input int plen, input bit drop, input bit model);
        logic [HW-1:0] h;
        logic [7:0]    all[$];
        logic [7:0]    b;
        h = '0;
        pay_q.delete();
        for (int i = 0; i < HB; i++) begin
            b = 8'($urandom);
            h[HW-1-8*i -: 8] = b;
            if (i < hlen) all.push_back(b);
        end
        for (int i = 0; i < plen; i++) begin
            b = 8'($urandom);
            pay_q.push_back(b);
            all.push_back(b);
        end
        if (model && !drop) begin
            for (int k = 0; k * DB < all.size(); k++) begin
                beat_t bt;
                bt.d = '0;
                for (int j = 0; j < DB && k * DB + j < all.size(); j++)
                    bt.d[DW-1-8*j -: 8] = all[k*DB+j];
                bt.last  = ((k + 1) * DB >= all.size());
                bt.bytes = bt.last ? 7'(all.size() - k * DB) : 7'(DB);
                sb.push_back(bt);
            end
        end
        pkt_id++;
        i_head     = {1'b1, drop, 6'(pkt_id), h};
        i_head_len = 8'(hlen);
        @(posedge i_clk); #1;
        i_head     = '0;
        i_head_len = 8'd0;
    endtask

    task automatic send_pay();
        int            plen;
        int            nb;
        int            tmo;
        bit            acc;
        logic [DW-1:0] d;
        plen = pay_q.size();
        nb   = (plen + DB - 1) / DB;
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < DW / 32; j++) d[32*j +: 32] = $urandom;
            for (int j = 0; j < DB; j++)
                if (k * DB + j < plen) d[DW-1-8*j -: 8] = pay_q[k*DB+j];
            i_pay_valid = 1'b1;
            i_pay_data  = d;
            i_pay_last  = (k == nb - 1);
            i_pay_bytes = (k == nb - 1) ? 7'(plen - k * DB) : 7'(DB);
            acc = 1'b0;
            tmo = 0;
            while (!acc && tmo < 2000) begin
                @(negedge i_clk);
                acc = o_pay_ready;
                @(posedge i_clk); #1;
                tmo++;
            end
            checks++;
            assert (acc) else begin
                errors++;
                $error("FAIL pay_timeout: observed ready=0 for %0d cycles, expected beat accepted", tmo);
            end
        end
        i_pay_valid = 1'b0;
        i_pay_last  = 1'b0;
        i_pay_data  = '0;
        i_pay_bytes = 7'd0;
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 3000) begin
            @(posedge i_clk); #1;
            i++;
        end
        repeat (3) @(posedge i_clk);
        #1;
        check("drain_left", DW'(sb.size()), DW'(0));
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge i_clk); #1;
            case (ready_mode)
                0:       i_pkt_ready = 1'b1;
                1:       i_pkt_ready = ($urandom_range(0, 3) != 0);
                default: i_pkt_ready = 1'b0;
            endcase
        end
    endtask

    // Compares each transferred beat with the scoreboard; checks hold while stalled
    task automatic mon_loop();
        logic [DW-1:0] hold_d;
        bit            hold_p;
        beat_t         bt;
        hold_p = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge i_clk);
            if (mon_en && i_rst_n) begin
                if (hold_p) begin
                    check("hold_valid", DW'(o_pkt_valid), DW'(1'b1));
                    check("hold_data", o_pkt_data, hold_d);
                end
                hold_p = 1'b0;
                if (o_pkt_valid && i_pkt_ready) begin
                    checks++;
                    assert (sb.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_beat: observed beat %0h, expected none", o_pkt_data);
                    end
                    if (sb.size() != 0) begin
                        bt = sb.pop_front();
                        check("beat_data", o_pkt_data, bt.d);
                        check("beat_last", DW'(o_pkt_last), DW'(bt.last));
                        check("beat_bytes", DW'(o_pkt_bytes), DW'(bt.bytes));
                    end
                end else if (o_pkt_valid) begin
                    hold_p = 1'b1;
                    hold_d = o_pkt_data;
                end
            end else begin
                hold_p = 1'b0;
            end
        end
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_head      = '0;
        i_head_len  = 8'd0;
        i_pay_valid = 1'b0;
        i_pay_data  = '0;
        i_pay_last  = 1'b0;
        i_pay_bytes = 7'd0;
        i_pkt_ready = 1'b1;
        fork
            ready_loop();
            mon_loop();
        join_none
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", DW'(o_pkt_valid), DW'(1'b0));
        check("rst_data", o_pkt_data, DW'(0));
        check("rst_last", DW'(o_pkt_last), DW'(1'b0));
        check("rst_bytes", DW'(o_pkt_bytes), DW'(0));
        check("rst_pay_ready", DW'(o_pay_ready), DW'(1'b0));
        check("rst_afull", DW'(o_head_afull), DW'(1'b0));
        check("rst_overflow", DW'(o_overflow), DW'(1'b0));
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Full-width header, three payload beats; first beat two cycles after the push
        start_pkt(128, 138, 1'b0, 1'b1);
        check("lat_push", DW'(o_pkt_valid), DW'(1'b0));
        @(posedge i_clk); #1;
        check("lat_pop", DW'(o_pkt_valid), DW'(1'b0));
        @(posedge i_clk); #1;
        check("lat_first", DW'(o_pkt_valid), DW'(1'b1));
        send_pay();
        wait_drain();

        // Residue carried past the last payload beat (flush path)
        start_pkt(42, 94, 1'b0, 1'b1);
        send_pay();
        wait_drain();

        // Header and payload share one beat
        start_pkt(20, 40, 1'b0, 1'b1);
        send_pay();
        wait_drain();

        // Dropped packet followed by a normal one; then zero-length header
        start_pkt(30, 100, 1'b1, 1'b1);
        send_pay();
        start_pkt(14, 70, 1'b0, 1'b1);
        send_pay();
        start_pkt(0, 150, 1'b0, 1'b1);
        send_pay();
        wait_drain();

        // Random lengths under 25% output stall
        ready_mode = 1;
        for (int p = 0; p < 200; p++) begin
            start_pkt($urandom_range(0, HB), $urandom_range(1, 300),
                      ($urandom_range(0, 9) == 0), 1'b1);
            send_pay();
        end
        wait_drain();

        // Fill the header FIFO behind a stalled packet, then reset mid-packet
        mon_en     = 1'b0;
        ready_mode = 2;
        @(posedge i_clk); #1;
        start_pkt(128, 10, 1'b0, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        for (int k = 1; k <= 9; k++) begin
            start_pkt(10, 10, 1'b0, 1'b0);
            check($sformatf("afull_push%0d", k), DW'(o_head_afull), DW'(k >= 6));
            check($sformatf("overflow_push%0d", k), DW'(o_overflow), DW'(k >= 9));
        end
        check("stalled_valid", DW'(o_pkt_valid), DW'(1'b1));
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", DW'(o_pkt_valid), DW'(1'b0));
        check("mid_rst_data", o_pkt_data, DW'(0));
        check("mid_rst_last", DW'(o_pkt_last), DW'(1'b0));
        check("mid_rst_bytes", DW'(o_pkt_bytes), DW'(0));
        check("mid_rst_pay_ready", DW'(o_pay_ready), DW'(1'b0));
        check("mid_rst_afull", DW'(o_head_afull), DW'(1'b0));
        check("mid_rst_overflow", DW'(o_overflow), DW'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
